// File: rtl/mod_addsub_seq.sv
// -----------------------------------------------------------------------------
// mod_addsub_seq
//   Sequential modular adder/subtractor for the RSA/Montgomery datapath.
//   Computes (A+B) mod M or (A-B) mod M using a single W-bit adder that is
//   reused over K = N/W chunks. The first pass forms S = A +/- B; the second
//   pass forms the corrected value D = S -/+ M. The final carries choose
//   between S and D. The latency is fixed at 2K+1 cycles from the start cycle
//   to the done cycle.
//
// Ports
//   clk       in   1   clock; all state changes on the rising edge
//   rst       in   1   synchronous reset, active-high
//   start     in   1   one-cycle request; sampled only in IDLE
//   subtract  in   1   0: A+B mod M, 1: A-B mod M; latched with start
//   A, B, M   in   N   operands and modulus; latched with start
//   result    out  N   modular result; held from one done to the next
//   done      out  1   one-cycle pulse; result is valid in the same cycle
//   busy      out  1   high from the cycle after start through the done cycle
// -----------------------------------------------------------------------------
module mod_addsub_seq #(
    parameter int N = 512,
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         subtract,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [N-1:0] M,
    output logic [N-1:0] result,
    output logic         done,
    output logic         busy
);

    localparam int K  = N / W;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    generate
        if (N % W != 0) begin : g_bad_width
            $error("mod_addsub_seq: N must be a multiple of W");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
        PASS2 = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t r_state, w_next;

    // Operand registers shift right by W each chunk, so the active chunk is
    // always in the low W bits. r_a is free after pass 1 and collects D.
    logic [N-1:0]  r_a, r_b, r_m, r_s, r_result;
    logic          r_sub, r_c, r_c1;
    logic [CW-1:0] r_cnt;

    logic          w_last, w_cin, w_cout, w_sel, w_pass2;
    logic [W-1:0]  w_x, w_y, w_sum;
    logic [N-1:0]  w_a_shin, w_s_shin, w_s_rot;

    assign w_last  = (r_cnt == LAST);
    assign w_pass2 = (r_state == PASS2);

    // Single shared W-bit adder. The carry init of each pass is taken on
    // chunk 0: pass 1 uses subtract (two's complement of B), pass 2 uses the
    // inverse (S-M for add, S+M for sub).
    always_comb begin
        w_x   = w_pass2 ? r_s[W-1:0] : r_a[W-1:0];
        w_y   = w_pass2 ? (r_sub ? r_m[W-1:0] : ~r_m[W-1:0]) : r_b[W-1:0];
        w_cin = (r_cnt == '0) ? (w_pass2 ? ~r_sub : r_sub) : r_c;
        {w_cout, w_sum} = {1'b0, w_x} + {1'b0, w_y} + {{W{1'b0}}, w_cin};
    end

    // Shift the new chunk in at the top; after K chunks the word is aligned.
    assign w_a_shin = (r_a >> W) | (N'(w_sum) << (N - W));
    assign w_s_shin = (r_s >> W) | (N'(w_sum) << (N - W));
    // S is rotated in pass 2 so that it is intact again after K chunks.
    assign w_s_rot  = (r_s >> W) | (r_s << (N - W));

    // Add: take D when A+B overflowed 2^N or S >= M.
    // Sub: take D (S+M) when the first pass borrowed, i.e. A < B.
    // w_cout is the pass-2 final carry when this is used on the last chunk.
    assign w_sel = r_sub ? ~r_c1 : (r_c1 | w_cout);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start)  w_next = PASS1;
            PASS1:   if (w_last) w_next = PASS2;
            PASS2:   if (w_last) w_next = DONE;
            DONE:                w_next = IDLE;
            default:             w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_m      <= '0;
            r_s      <= '0;
            r_result <= '0;
            r_sub    <= 1'b0;
            r_c      <= 1'b0;
            r_c1     <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a   <= A;
                        r_b   <= subtract ? ~B : B;
                        r_m   <= M;
                        r_sub <= subtract;
                        r_cnt <= '0;
                        r_c   <= 1'b0;
                    end
                end
                PASS1: begin
                    r_a   <= r_a >> W;
                    r_b   <= r_b >> W;
                    r_s   <= w_s_shin;
                    r_c   <= w_cout;
                    r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                    if (w_last) r_c1 <= w_cout;
                end
                PASS2: begin
                    r_a   <= w_a_shin;
                    r_m   <= r_m >> W;
                    r_s   <= w_s_rot;
                    r_c   <= w_cout;
                    r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                    // Registered on entry to DONE so result and done align.
                    if (w_last) r_result <= w_sel ? w_a_shin : w_s_rot;
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign done   = (r_state == DONE);
    assign busy   = (r_state != IDLE);

endmodule

// File: tb/tb_mod_addsub_seq.sv
module tb_mod_addsub_seq;

    localparam int N = 512;
    localparam int W = 128;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         subtract = 1'b0;
    logic [N-1:0] A = '0, B = '0, M = '0;
    logic [N-1:0] result;
    logic         done, busy;

    int n_vec = 0;
    int n_err = 0;

    mod_addsub_seq #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .subtract(subtract),
        .A(A), .B(B), .M(M),
        .result(result), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] rnd();
        logic [N-1:0] r;
        for (int i = 0; i < N / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference: plain wide arithmetic with an explicit compare against M.
    function automatic logic [N-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [N-1:0] m, input logic sub);
        logic [N:0] t;
        if (!sub) begin
            t = {1'b0, a} + {1'b0, b};
            if (t >= {1'b0, m}) t = t - {1'b0, m};
        end else if (a >= b) begin
            t = {1'b0, a} - {1'b0, b};
        end else begin
            t = {1'b0, a} + {1'b0, m} - {1'b0, b};
        end
        return t[N-1:0];
    endfunction

    // Starts an op in the next cycle (cycle 0) and follows it to cycle 9.
    // Inputs are scrambled after acceptance; ign pulses start at cycles 3 and 9.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] m,
                          input logic sub, input logic [N-1:0] exp, input bit ign, input string tag);
        @(posedge clk); #1;
        A = a; B = b; M = m; subtract = sub; start = 1'b1;
        @(negedge clk);
        chk({tag, "_c0_busy"}, N'(busy), N'(0));
        chk({tag, "_c0_done"}, N'(done), N'(0));
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            A = rnd(); B = rnd(); M = rnd(); subtract = 1'($urandom);
            if (ign && (c == 3 || c == 9)) start = 1'b1;
            @(negedge clk);
            chk($sformatf("%s_c%0d_busy", tag, c), N'(busy), N'(1));
            chk($sformatf("%s_c%0d_done", tag, c), N'(done), N'(c == 9));
            if (c == 9) chk({tag, "_result"}, result, exp);
        end
    endtask

    initial begin
        logic [N-1:0] ones, a, b, m;
        logic         s;
        ones = '1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_result", result, '0);
        chk("rst_done", N'(done), N'(0));
        chk("rst_busy", N'(busy), N'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed vectors, hand-computed expectations
        run_op(512'd5,  512'd7, 512'd13, 1'b0, 512'd12, 1'b0, "add_5_7");
        run_op(512'd10, 512'd7, 512'd13, 1'b0, 512'd4,  1'b0, "add_10_7");
        run_op(512'd6,  512'd7, 512'd13, 1'b0, 512'd0,  1'b0, "add_eq_m");
        run_op(ones - 512'd1, ones - 512'd1, ones, 1'b0, ones - 512'd2, 1'b0, "add_c1");
        run_op((512'd1 << 128) - 512'd1, 512'd1, ones, 1'b0, 512'd1 << 128, 1'b0, "add_chunk");
        run_op(512'd9, 512'd4, 512'd13, 1'b1, 512'd5, 1'b0, "sub_9_4");
        run_op(512'd4, 512'd9, 512'd13, 1'b1, 512'd8, 1'b0, "sub_4_9");
        run_op(512'd1 << 384, 512'd1, ones, 1'b1, (512'd1 << 384) - 512'd1, 1'b0, "sub_borrow");
        run_op(512'd77, 512'd77, 512'd101, 1'b1, 512'd0, 1'b0, "sub_eq");

        // Starts during the op and in DONE are ignored; the next op follows at cycle 10
        run_op(512'd5,  512'd7, 512'd13, 1'b0, 512'd12, 1'b1, "ign");
        run_op(512'd10, 512'd7, 512'd13, 1'b0, 512'd4,  1'b0, "after_ign");

        // Reset in cycle 5 of an op aborts it
        @(posedge clk); #1;
        A = 512'd9; B = 512'd4; M = 512'd13; subtract = 1'b1; start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (c == 5) rst = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", N'(busy), N'(0));
        chk("abort_done", N'(done), N'(0));
        chk("abort_result", result, '0);
        for (int c = 7; c <= 12; c++) begin
            @(negedge clk);
            chk($sformatf("abort_nodone_c%0d", c), N'(done), N'(0));
        end
        run_op(512'd4, 512'd9, 512'd13, 1'b1, 512'd8, 1'b0, "post_abort");

        // Random back-to-back ops against the reference model
        for (int i = 0; i < 1000; i++) begin
            m = rnd() | 512'd1;
            a = rnd() % m;
            b = rnd() % m;
            s = 1'($urandom);
            run_op(a, b, m, s, model(a, b, m, s), 1'b0, $sformatf("rnd%0d", i));
        end
        @(posedge clk); #1;
        start = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
